// File: rtl/ram_sp_arb.sv
// ram_sp_arb: single-port synchronous RAM shared by one write requester and
// one read requester. A combinational arbiter picks at most one access per
// cycle (write priority with anti-starvation, or round-robin). Reads return
// data one cycle after acceptance. Contention cycles are counted in stall_cnt.
module ram_sp_arb #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 8,
   parameter int PRIO_MODE  = 0,
   parameter int MAX_STARVE = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_valid,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [15:0]       stall_cnt
);

   localparam int             LP_DEPTH      = 2 ** ADDR_W;
   localparam logic [7:0]     LP_MAX_STARVE = 8'(MAX_STARVE);

   // Which side won the most recent accepted request (round-robin history).
   typedef enum logic {
      LAST_RD = 1'b0,
      LAST_WR = 1'b1
   } last_e;

   logic [DATA_W-1:0] r_mem [0:LP_DEPTH-1];
   logic [7:0]        r_starve_cnt;
   last_e             r_last;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic [15:0]       r_stall_cnt;

   logic              w_both;
   logic              w_rd_wins;
   logic              w_wr_grant;
   logic              w_rd_grant;
   last_e             w_last_nxt;
   logic [7:0]        w_starve_nxt;
   logic [15:0]       w_stall_nxt;

   // Arbitration: decide which side wins when both request; lone requests win outright.
   always_comb begin
      w_both    = wr_valid && rd_valid;
      w_rd_wins = 1'b0;
      if (PRIO_MODE == 0) begin
         w_rd_wins = (r_starve_cnt == LP_MAX_STARVE);
      end else begin
         w_rd_wins = (r_last == LAST_WR);
      end
      // Grants are masked by reset so neither side is accepted while reset is held.
      w_wr_grant = reset_n && wr_valid && !(rd_valid && w_rd_wins);
      w_rd_grant = reset_n && rd_valid && !(wr_valid && !w_rd_wins);
   end

   // Next-state values for arbiter history, starvation counter and stall counter.
   always_comb begin
      w_last_nxt   = r_last;
      w_starve_nxt = 8'd0;
      w_stall_nxt  = r_stall_cnt;
      if (w_wr_grant) begin
         w_last_nxt = LAST_WR;
      end else if (w_rd_grant) begin
         w_last_nxt = LAST_RD;
      end
      // A pending read that lost ages; anything else (accepted or idle) clears it.
      if (rd_valid && !w_rd_grant) begin
         w_starve_nxt = (r_starve_cnt >= LP_MAX_STARVE) ? LP_MAX_STARVE
                                                        : r_starve_cnt + 8'd1;
      end
      if (w_both && (r_stall_cnt != 16'hFFFF)) begin
         w_stall_nxt = r_stall_cnt + 16'd1;
      end
   end

   // Control state and read response register, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last       <= LAST_RD;
         r_starve_cnt <= 8'd0;
         r_stall_cnt  <= 16'd0;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
      end else begin
         r_last       <= w_last_nxt;
         r_starve_cnt <= w_starve_nxt;
         r_stall_cnt  <= w_stall_nxt;
         r_rsp_valid  <= w_rd_grant;
         if (w_rd_grant) begin
            r_rsp_data <= r_mem[rd_addr];
         end
      end
   end

   // Storage array: written on the accepting edge, never reset.
   always_ff @(posedge clk) begin
      if (w_wr_grant) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign wr_ready  = w_wr_grant;
   assign rd_ready  = w_rd_grant;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ram_sp_arb.sv
// Testbench for ram_sp_arb: two instances (write-priority with MAX_STARVE=4,
// and round-robin) driven by directed steps and random requests, checked
// against a behavioural model of the arbitration and memory rules.
module tb_ram_sp_arb;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [1:0]       wv, rv, wrdy, rrdy, rspv;
   logic [1:0][7:0]  wa, wd, ra, rspd;
   logic [1:0][15:0] stall;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state, one set per instance (0: write priority, 1: round-robin).
   int         m_starve [2];
   bit         m_lastw  [2];
   int         m_stall  [2];
   logic [7:0] m_mem    [2][256];
   bit         m_known  [2][256];
   bit         m_rspv   [2];
   logic [7:0] m_rspd   [2];
   bit         m_rspk   [2];
   bit         e_wr     [2];
   bit         e_rd     [2];
   logic       obs_wr   [2];
   logic       obs_rd   [2];

   always #5 clk = ~clk;

   ram_sp_arb #(.DATA_W(8), .ADDR_W(8), .PRIO_MODE(0), .MAX_STARVE(4)) u_dut0 (
      .clk(clk), .reset_n(reset_n),
      .wr_valid(wv[0]), .wr_addr(wa[0]), .wr_data(wd[0]), .wr_ready(wrdy[0]),
      .rd_valid(rv[0]), .rd_addr(ra[0]), .rd_ready(rrdy[0]),
      .rsp_valid(rspv[0]), .rsp_data(rspd[0]), .stall_cnt(stall[0]));

   ram_sp_arb #(.DATA_W(8), .ADDR_W(8), .PRIO_MODE(1), .MAX_STARVE(4)) u_dut1 (
      .clk(clk), .reset_n(reset_n),
      .wr_valid(wv[1]), .wr_addr(wa[1]), .wr_data(wd[1]), .wr_ready(wrdy[1]),
      .rd_valid(rv[1]), .rd_addr(ra[1]), .rd_ready(rrdy[1]),
      .rsp_valid(rspv[1]), .rsp_data(rspd[1]), .stall_cnt(stall[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      for (int d = 0; d < 2; d++) begin
         m_starve[d] = 0;
         m_lastw[d]  = 1'b0;
         m_stall[d]  = 0;
         m_rspv[d]   = 1'b0;
         m_rspd[d]   = 8'h00;
         m_rspk[d]   = 1'b1;
         e_wr[d]     = 1'b0;
         e_rd[d]     = 1'b0;
         for (int a = 0; a < 256; a++) m_known[d][a] = 1'b0;
      end
   endfunction

   // Who should be granted this cycle, from the arbitration rules.
   function automatic void m_grant(input int d);
      bit rd_wins;
      e_wr[d] = 1'b0;
      e_rd[d] = 1'b0;
      if (reset_n === 1'b1) begin
         if (wv[d] && rv[d]) begin
            rd_wins = (d == 0) ? (m_starve[d] >= 4) : m_lastw[d];
            e_wr[d] = !rd_wins;
            e_rd[d] = rd_wins;
         end else begin
            e_wr[d] = wv[d];
            e_rd[d] = rv[d];
         end
      end
   endfunction

   // Effects of the rising edge on the model.
   function automatic void m_edge(input int d);
      if (wv[d] && rv[d]) m_stall[d] = (m_stall[d] < 65535) ? m_stall[d] + 1 : 65535;
      if (rv[d] && !e_rd[d]) m_starve[d] = (m_starve[d] < 4) ? m_starve[d] + 1 : 4;
      else                   m_starve[d] = 0;
      m_rspv[d] = e_rd[d];
      if (e_rd[d]) begin
         m_rspd[d]  = m_mem[d][ra[d]];
         m_rspk[d]  = m_known[d][ra[d]];
         m_lastw[d] = 1'b0;
      end
      if (e_wr[d]) begin
         m_mem[d][wa[d]]   = wd[d];
         m_known[d][wa[d]] = 1'b1;
         m_lastw[d]        = 1'b1;
      end
   endfunction

   // One clock cycle: inputs set at the falling edge, readies checked just
   // after, registered outputs checked just after the rising edge.
   task automatic cyc(input bit chk);
      #1;
      for (int d = 0; d < 2; d++) begin
         m_grant(d);
         obs_wr[d] = wrdy[d];
         obs_rd[d] = rrdy[d];
         if (chk) begin
            check($sformatf("d%0d_wr_ready", d), 32'(wrdy[d]), 32'(e_wr[d]));
            check($sformatf("d%0d_rd_ready", d), 32'(rrdy[d]), 32'(e_rd[d]));
         end
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) m_edge(d);
      #1;
      if (chk) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_rsp_valid", d), 32'(rspv[d]), 32'(m_rspv[d]));
            if (m_rspk[d]) check($sformatf("d%0d_rsp_data", d), 32'(rspd[d]), 32'(m_rspd[d]));
            check($sformatf("d%0d_stall_cnt", d), 32'(stall[d]), 32'(m_stall[d]));
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      wv = '0;
      rv = '0;
      m_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      wv = 2'b11; rv = 2'b11;
      wa = '0; wd = '0; ra = '0;
      m_reset();
      repeat (2) @(negedge clk);
      #1;
      // Reset state, with both requests asserted to show no grant leaks through.
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_d%0d_wr_ready", d), 32'(wrdy[d]), 32'd0);
         check($sformatf("rst_d%0d_rd_ready", d), 32'(rrdy[d]), 32'd0);
         check($sformatf("rst_d%0d_rsp_valid", d), 32'(rspv[d]), 32'd0);
         check($sformatf("rst_d%0d_rsp_data", d), 32'(rspd[d]), 32'd0);
         check($sformatf("rst_d%0d_stall", d), 32'(stall[d]), 32'd0);
      end
      @(negedge clk);
      wv = '0; rv = '0;
      reset_n = 1'b1;

      // Uncontended writes of 2,4,6,8 to addresses 0..3, then reads back.
      for (int i = 0; i < 4; i++) begin
         wv[0] = 1'b1; wa[0] = 8'(i); wd[0] = 8'(2 * (i + 1));
         cyc(1);
         check("w4_wr_ready", 32'(obs_wr[0]), 32'd1);
      end
      wv[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rv[0] = 1'b1; ra[0] = 8'(i);
         cyc(1);
         check("r4_rsp_valid", 32'(rspv[0]), 32'd1);
         check("r4_rsp_data", 32'(rspd[0]), 32'(2 * (i + 1)));
      end
      rv[0] = 1'b0;
      cyc(1);

      // Write priority with starvation limit 4: W W W W R repeating.
      wv[0] = 1'b1; wa[0] = 8'h20; wd[0] = 8'h11;
      rv[0] = 1'b1; ra[0] = 8'h20;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         check("prio_grant", {30'd0, obs_wr[0], obs_rd[0]}, (i % 5 == 4) ? 32'd1 : 32'd2);
      end
      check("prio_stall10", 32'(stall[0]), 32'd10);
      wv[0] = 1'b0; rv[0] = 1'b0;
      cyc(1);

      // Read in the cycle right after a write to the same address.
      wv[0] = 1'b1; wa[0] = 8'h07; wd[0] = 8'hA5;
      cyc(1);
      wv[0] = 1'b0; rv[0] = 1'b1; ra[0] = 8'h07;
      cyc(1);
      check("raw_rsp_valid", 32'(rspv[0]), 32'd1);
      check("raw_rsp_data", 32'(rspd[0]), 32'hA5);

      // Reset asserted while a response is being presented.
      rv[0] = 1'b1; ra[0] = 8'h07;
      cyc(1);
      rv[0] = 1'b0;
      reset_n = 1'b0;
      #1;
      check("async_rsp_valid", 32'(rspv[0]), 32'd0);
      check("async_rsp_data", 32'(rspd[0]), 32'd0);
      check("async_stall", 32'(stall[0]), 32'd0);
      m_reset();
      @(negedge clk);
      reset_n = 1'b1;

      // Round-robin from reset: W R W R ..., write first.
      wv[1] = 1'b1; wa[1] = 8'h40; wd[1] = 8'h5C;
      rv[1] = 1'b1; ra[1] = 8'h40;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         check("rr_grant", {30'd0, obs_wr[1], obs_rd[1]}, (i % 2 == 0) ? 32'd2 : 32'd1);
      end
      wv[1] = 1'b0; rv[1] = 1'b0;
      cyc(1);

      // Random traffic on both instances; a request is held until accepted.
      for (int n = 0; n < 1500; n++) begin
         for (int d = 0; d < 2; d++) begin
            if (!(wv[d] && !e_wr[d])) begin
               wv[d] = ($urandom_range(0, 3) != 0);
               wa[d] = 8'($urandom_range(0, 15));
               wd[d] = 8'($urandom);
            end
            if (!(rv[d] && !e_rd[d])) begin
               rv[d] = ($urandom_range(0, 3) != 0);
               ra[d] = 8'($urandom_range(0, 15));
            end
         end
         cyc(1);
      end

      // Continuous contention long enough to saturate the stall counter.
      do_reset();
      wv = 2'b11; rv = 2'b11;
      wa[0] = 8'h30; wd[0] = 8'h3C; ra[0] = 8'h30;
      wa[1] = 8'h31; wd[1] = 8'hC3; ra[1] = 8'h31;
      repeat (65600) cyc(0);
      cyc(1);
      cyc(1);
      check("sat_d0_stall", 32'(stall[0]), 32'h0000FFFF);
      check("sat_d1_stall", 32'(stall[1]), 32'h0000FFFF);
      wv = '0; rv = '0;
      cyc(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
